seq_event_monitor: RTL

- Downstream consumer of the 1-bit decision stream produced by the 2-bit a/b decode stage.
- Qualifies each decision bit with in_valid and runs an overlapping 1-0-1 pattern detector on the stream.
- Each match produces an event tagged with the {a,b} operands of the completing sample, pushed out through a 1-entry valid/ready buffer.
- Keeps saturating match and drop counters for status readback.

---
 rtl/seq_mon_pkg.sv | 17 +
 rtl/sat_counter.sv | 24 ++
 rtl/seq_event_monitor.sv | 97 +++++++++
 3 files changed

// File: rtl/seq_mon_pkg.sv
// Shared types and constants for the 1-0-1 event monitor.
package seq_mon_pkg;

  // Detector state: how much of the 1-0-1 pattern has been seen so far.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_S1   = 2'b01,
    ST_S10  = 2'b10
  } state_t;

  // Pattern bits, oldest first (PATTERN[2] is the first bit of the pattern).
  localparam logic [2:0] PATTERN = 3'b101;

  // Event code carries {a,b} of the completing sample.
  localparam int EVT_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Counter register; reset and clear both return it to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (inc)   count <= sat_inc(count);
  end

endmodule

// File: rtl/seq_event_monitor.sv
// Overlapping 1-0-1 detector on a qualified bit stream, with a one-entry
// valid/ready event buffer and saturating match/drop counters.
module seq_event_monitor
  import seq_mon_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_a,
  input  logic [1:0]       in_b,
  input  logic             in_bit,
  input  logic             clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [EVT_W-1:0] evt_code,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [1:0]       state_o
);

  state_t state_q, state_d;
  logic   hit;
  logic   match;
  logic   load;
  logic   drop;

  // State register; clear behaves like reset for the detector.
  always_ff @(posedge clk) begin
    if (rst || clr) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state decode; the FSM only advances on qualified samples.
  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && (in_bit == PATTERN[2])) state_d = ST_S1;
      end
      ST_S1: begin
        if (in_valid && (in_bit == PATTERN[1])) state_d = ST_S10;
      end
      ST_S10: begin
        if (in_valid) begin
          if (in_bit == PATTERN[0]) begin
            hit     = 1'b1;
            state_d = ST_S1;      // trailing 1 restarts the pattern (overlap)
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE; // unused encoding recovers to idle
    endcase
  end

  // A sample presented together with clr is discarded. A match loads the
  // buffer when it is empty or being drained this cycle; otherwise it drops.
  assign match = hit & ~clr;
  assign load  = match & (~evt_valid | evt_ready);
  assign drop  = match & evt_valid & ~evt_ready;

  // One-entry event buffer; code is held while the entry waits for ready.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      evt_valid <= 1'b0;
      evt_code  <= '0;
    end else if (load) begin
      evt_valid <= 1'b1;
      evt_code  <= {in_a, in_b};
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (match),
    .count (match_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (drop),
    .count (drop_cnt)
  );

  assign state_o = state_q;

endmodule
